// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// mem_port_arbiter_pkg
//   Shared state encodings, arbitration modes and the confreg address remap.
//   Revision: 1.0
// ============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BUSY  = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  localparam logic [15:0] CONFREG_VSEG = 16'hbfaf;
  localparam logic [15:0] CONFREG_PSEG = 16'h1faf;

  function automatic logic [31:0] remap_addr(input logic [31:0] a, input logic en);
    remap_addr = (en && (a[31:16] == CONFREG_VSEG)) ? {CONFREG_PSEG, a[15:0]} : a;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_arb_pick.sv
// ============================================================================
// arb_pick
//   Combinational winner select: lowest index (fixed) or first from ptr (RR).
//   Revision: 1.0
// ============================================================================
`default_nettype none

module arb_pick #(
  parameter int N_CH = 2,
  parameter int IW   = 1
) (
  input  logic [N_CH-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  input  logic            i_mode,
  output logic [N_CH-1:0] o_gnt,
  output logic [IW-1:0]   o_idx
);

  logic [IW-1:0]   w_start;
  logic [N_CH-1:0] w_rot;
  logic [IW-1:0]   w_off;
  logic [IW:0]     w_sum;
  logic            w_found;

  // Rotating the doubled vector puts the search start at bit 0.
  assign w_start = i_mode ? i_ptr : '0;
  assign w_rot   = N_CH'({i_req, i_req} >> w_start);

  always_comb begin
    w_off   = '0;
    w_found = 1'b0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off   = IW'(k);
        w_found = 1'b1;
      end
    end
  end

  assign w_sum = {1'b0, w_start} + {1'b0, w_off};
  assign o_idx = (w_sum >= (IW+1)'(N_CH)) ? IW'(w_sum - (IW+1)'(N_CH)) : IW'(w_sum);
  assign o_gnt = w_found ? (N_CH'(1) << o_idx) : '0;

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter
//   N-channel cache-to-AXI port arbiter with per-transaction grant lock and flush drain.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int              N_CH       = 2,
  parameter int              ARB_MODE   = ARB_FIXED,
  parameter logic [N_CH-1:0] FLUSH_MASK = 2'b10,
  parameter int              REMAP_EN   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [N_CH-1:0]    ch_strobe,
  input  logic [N_CH-1:0]    ch_rw,
  input  logic [32*N_CH-1:0] ch_a,
  input  logic [2*N_CH-1:0]  ch_size,
  input  logic [4*N_CH-1:0]  ch_sel,
  input  logic [32*N_CH-1:0] ch_wdata,
  output logic [N_CH-1:0]    ch_ready,
  output logic [31:0]        ch_rdata,
  output logic [N_CH-1:0]    grant,
  output logic               mem_access,
  output logic               mem_write,
  output logic [31:0]        mem_a,
  output logic [1:0]         mem_size,
  output logic [3:0]         mem_sel,
  output logic [31:0]        mem_st_data,
  input  logic               mem_ready,
  input  logic [31:0]        mem_data
);

  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

  arb_state_t      r_state, w_next;
  logic [N_CH-1:0] r_grant, w_req, w_gnt;
  logic [IW-1:0]   r_idx, w_idx, r_rr_ptr;
  logic            r_write, w_pl_write;
  logic [31:0]     r_a, w_pl_a, r_wdata, w_pl_wdata;
  logic [1:0]      r_size, w_pl_size;
  logic [3:0]      r_sel, w_pl_sel;
  logic            w_latch;

  // Flush pulls masked (data-side) channels out of the current arbitration round.
  assign w_req   = ch_strobe & ~(flush ? FLUSH_MASK : '0);
  assign w_latch = (r_state == ARB_IDLE) && (|w_req);

  arb_pick #(.N_CH(N_CH), .IW(IW)) u_pick (
    .i_req  (w_req),
    .i_ptr  (r_rr_ptr),
    .i_mode (ARB_MODE == ARB_RR),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx)
  );

  always_comb begin
    w_pl_write = 1'b0;
    w_pl_a     = '0;
    w_pl_size  = '0;
    w_pl_sel   = '0;
    w_pl_wdata = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (w_idx == IW'(k)) begin
        w_pl_write = ch_rw[k];
        w_pl_a     = ch_a[32*k +: 32];
        w_pl_size  = ch_size[2*k +: 2];
        w_pl_sel   = ch_sel[4*k +: 4];
        w_pl_wdata = ch_wdata[32*k +: 32];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ARB_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ARB_IDLE:  if (|w_req) w_next = ARB_BUSY;
      ARB_BUSY: begin
        // A ready in the flush cycle wins: the transaction counts as completed.
        if (mem_ready)                          w_next = ARB_IDLE;
        else if (flush && |(r_grant & FLUSH_MASK)) w_next = ARB_DRAIN;
      end
      ARB_DRAIN: if (mem_ready) w_next = ARB_IDLE;
      default:   w_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant  <= '0;
      r_idx    <= '0;
      r_rr_ptr <= '0;
      r_write  <= 1'b0;
      r_a      <= '0;
      r_size   <= '0;
      r_sel    <= '0;
      r_wdata  <= '0;
    end else begin
      if (w_latch) begin
        r_grant <= w_gnt;
        r_idx   <= w_idx;
        r_write <= w_pl_write;
        r_a     <= w_pl_a;
        r_size  <= w_pl_size;
        r_sel   <= w_pl_sel;
        r_wdata <= w_pl_wdata;
      end else if ((r_state != ARB_IDLE) && mem_ready) begin
        r_grant <= '0;
      end
      // Drained transactions leave the round-robin pointer untouched.
      if ((r_state == ARB_BUSY) && mem_ready)
        r_rr_ptr <= (r_idx == IW'(N_CH - 1)) ? '0 : r_idx + IW'(1);
    end
  end

  assign grant       = r_grant;
  assign mem_access  = (r_state != ARB_IDLE);
  assign mem_write   = r_write;
  assign mem_a       = remap_addr(r_a, REMAP_EN != 0);
  assign mem_size    = r_size;
  assign mem_sel     = r_sel;
  assign mem_st_data = r_wdata;
  assign ch_ready    = ((r_state == ARB_BUSY) && mem_ready) ? r_grant : '0;
  assign ch_rdata    = mem_data;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter
//   Self-checking bench: fixed/2-channel and round-robin/4-channel instances.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: fixed priority, 2 channels, ch1 flushable, remap on
  logic        flush_a = 1'b0;
  logic [1:0]  strobe_a = '0, rw_a = '0, ready_a, grant_a;
  logic [63:0] a_a = '0, wd_a = '0;
  logic [3:0]  size_a = '0;
  logic [7:0]  sel_a = '0;
  logic [31:0] rdata_a, mem_a_a, mem_st_a, mem_data_a = '0;
  logic        access_a, write_a, mem_ready_a = 1'b0;
  logic [1:0]  mem_size_a;
  logic [3:0]  mem_sel_a;

  // Instance B: round robin, 4 channels, no flush mask
  logic [3:0]   strobe_b = '0, ready_b, grant_b;
  logic [127:0] a_b = '0;
  logic [31:0]  rdata_b, mem_a_b, mem_st_b;
  logic         access_b, write_b, mem_ready_b = 1'b0;
  logic [1:0]   mem_size_b;
  logic [3:0]   mem_sel_b;

  mem_port_arbiter #(.N_CH(2), .ARB_MODE(0), .FLUSH_MASK(2'b10), .REMAP_EN(1)) dut_a (
    .clk(clk), .rst(rst), .flush(flush_a), .ch_strobe(strobe_a), .ch_rw(rw_a),
    .ch_a(a_a), .ch_size(size_a), .ch_sel(sel_a), .ch_wdata(wd_a),
    .ch_ready(ready_a), .ch_rdata(rdata_a), .grant(grant_a), .mem_access(access_a),
    .mem_write(write_a), .mem_a(mem_a_a), .mem_size(mem_size_a), .mem_sel(mem_sel_a),
    .mem_st_data(mem_st_a), .mem_ready(mem_ready_a), .mem_data(mem_data_a));

  mem_port_arbiter #(.N_CH(4), .ARB_MODE(1), .FLUSH_MASK(4'b0000), .REMAP_EN(1)) dut_b (
    .clk(clk), .rst(rst), .flush(1'b0), .ch_strobe(strobe_b), .ch_rw(4'b0000),
    .ch_a(a_b), .ch_size(8'h00), .ch_sel(16'h0000), .ch_wdata(128'h0),
    .ch_ready(ready_b), .ch_rdata(rdata_b), .grant(grant_b), .mem_access(access_b),
    .mem_write(write_b), .mem_a(mem_a_b), .mem_size(mem_size_b), .mem_sel(mem_sel_b),
    .mem_st_data(mem_st_b), .mem_ready(mem_ready_b), .mem_data(32'h0));

  typedef struct {
    int          ch;
    logic        rw;
    logic [31:0] a;
    logic [1:0]  size;
    logic [3:0]  sel;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [31:0] exp_a;
    int          lat;
  } vec_t;

  typedef struct {
    logic [1:0]  rdy;
    logic [31:0] data;
  } exp_t;

  vec_t vecs[5];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int ch, input logic [31:0] d);
    exp_t e;
    e.rdy = '0;
    e.rdy[ch] = 1'b1;
    e.data = d;
    sb.push_back(e);
  endtask

  // Called #1 after mem_ready is raised: compare against the oldest expectation.
  task automatic check_sb();
    exp_t e;
    if (sb.size() == 0) begin
      chk("ch_ready_unexpected", {30'd0, ready_a}, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("ch_ready", {30'd0, ready_a}, {30'd0, e.rdy});
      chk("ch_rdata", rdata_a, e.data);
    end
  endtask

  task automatic set_ch(input vec_t v);
    rw_a[v.ch]            = v.rw;
    a_a[32*v.ch +: 32]    = v.a;
    size_a[2*v.ch +: 2]   = v.size;
    sel_a[4*v.ch +: 4]    = v.sel;
    wd_a[32*v.ch +: 32]   = v.wd;
  endtask

  task automatic run_txn(input vec_t v);
    logic [1:0] g;
    g = '0;
    g[v.ch] = 1'b1;
    @(negedge clk);
    set_ch(v);
    strobe_a = g;
    @(negedge clk);
    chk("txn_access", {31'd0, access_a}, 32'd1);
    chk("txn_grant", {30'd0, grant_a}, {30'd0, g});
    chk("txn_mem_a", mem_a_a, v.exp_a);
    chk("txn_write", {31'd0, write_a}, {31'd0, v.rw});
    chk("txn_sel", {28'd0, mem_sel_a}, {28'd0, v.sel});
    chk("txn_size", {30'd0, mem_size_a}, {30'd0, v.size});
    chk("txn_wdata", mem_st_a, v.wd);
    strobe_a = '0;
    a_a[32*v.ch +: 32] = 32'hFFFF_FFFF;
    push_exp(v.ch, v.rd);
    for (int i = 0; i < v.lat; i++) begin
      @(negedge clk);
      chk("txn_wait_ready", {30'd0, ready_a}, 32'd0);
      chk("txn_hold_a", mem_a_a, v.exp_a);
    end
    mem_ready_a = 1'b1;
    mem_data_a  = v.rd;
    #1 check_sb();
    @(negedge clk);
    mem_ready_a = 1'b0;
    chk("txn_idle_access", {31'd0, access_a}, 32'd0);
    chk("txn_idle_grant", {30'd0, grant_a}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{0, 1'b0, 32'h0000_1000, 2'd2, 4'hF,    32'h0,         32'h1111_1111, 32'h0000_1000, 3};
    vecs[1] = '{1, 1'b1, 32'hbfaf_8000, 2'd1, 4'b0011, 32'h0000_CAFE, 32'h0,         32'h1faf_8000, 1};
    vecs[2] = '{1, 1'b0, 32'h8000_0010, 2'd2, 4'hF,    32'h0,         32'hA5A5_5A5A, 32'h8000_0010, 0};
    vecs[3] = '{0, 1'b0, 32'hbfaf_0004, 2'd2, 4'hF,    32'h0,         32'h1234_5678, 32'h1faf_0004, 2};
    vecs[4] = '{0, 1'b1, 32'hbfae_0000, 2'd0, 4'b0100, 32'h0000_00AB, 32'h0,         32'hbfae_0000, 1};

    // Reset state
    @(negedge clk);
    chk("rst_access", {31'd0, access_a}, 32'd0);
    chk("rst_grant", {30'd0, grant_a}, 32'd0);
    chk("rst_ready", {30'd0, ready_a}, 32'd0);
    chk("rst_mem_a", mem_a_a, 32'd0);
    chk("rst_write", {31'd0, write_a}, 32'd0);
    chk("rst_sel", {28'd0, mem_sel_a}, 32'd0);
    chk("rst_st_data", mem_st_a, 32'd0);
    chk("rst_b_grant", {28'd0, grant_b}, 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) run_txn(vecs[i]);

    // Simultaneous ch0/ch1: ch0 first, ch1 after one idle cycle
    @(negedge clk);
    a_a = {32'h0000_2222, 32'h0000_1111};
    rw_a = '0;
    strobe_a = 2'b11;
    @(negedge clk);
    chk("both_grant0", {30'd0, grant_a}, 32'd1);
    chk("both_mem_a0", mem_a_a, 32'h0000_1111);
    push_exp(0, 32'h0000_00C0);
    repeat (3) @(negedge clk);
    mem_ready_a = 1'b1;
    mem_data_a  = 32'h0000_00C0;
    #1 check_sb();
    @(negedge clk);
    strobe_a = 2'b10;
    mem_ready_a = 1'b0;
    chk("both_idle_gap", {30'd0, grant_a}, 32'd0);
    chk("both_idle_access", {31'd0, access_a}, 32'd0);
    @(negedge clk);
    chk("both_grant1", {30'd0, grant_a}, 32'd2);
    chk("both_mem_a1", mem_a_a, 32'h0000_2222);
    strobe_a = '0;
    push_exp(1, 32'h0000_00C1);
    mem_ready_a = 1'b1;
    mem_data_a  = 32'h0000_00C1;
    #1 check_sb();
    @(negedge clk);
    mem_ready_a = 1'b0;

    // Flush one cycle into BUSY on ch1: drain, no ch_ready
    @(negedge clk);
    a_a[63:32] = 32'h8000_0010;
    strobe_a = 2'b10;
    @(negedge clk);
    chk("drain_grant", {30'd0, grant_a}, 32'd2);
    flush_a = 1'b1;
    strobe_a = '0;
    @(negedge clk);
    flush_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("drain_access", {31'd0, access_a}, 32'd1);
      chk("drain_mem_a", mem_a_a, 32'h8000_0010);
      chk("drain_ready", {30'd0, ready_a}, 32'd0);
      @(negedge clk);
    end
    mem_ready_a = 1'b1;
    mem_data_a  = 32'h5555_AAAA;
    #1 check_sb();
    @(negedge clk);
    mem_ready_a = 1'b0;
    chk("drain_done_access", {31'd0, access_a}, 32'd0);
    chk("drain_done_grant", {30'd0, grant_a}, 32'd0);

    // Flush on the cycle of mem_ready: completion wins
    @(negedge clk);
    strobe_a = 2'b10;
    @(negedge clk);
    strobe_a = '0;
    push_exp(1, 32'hDEAD_BEEF);
    flush_a = 1'b1;
    mem_ready_a = 1'b1;
    mem_data_a  = 32'hDEAD_BEEF;
    #1 check_sb();
    @(negedge clk);
    flush_a = 1'b0;
    mem_ready_a = 1'b0;
    chk("flush_rdy_idle", {31'd0, access_a}, 32'd0);

    // Flush in IDLE masks ch1 out of arbitration for that cycle
    @(negedge clk);
    strobe_a = 2'b10;
    flush_a = 1'b1;
    @(negedge clk);
    chk("idle_flush_access", {31'd0, access_a}, 32'd0);
    chk("idle_flush_grant", {30'd0, grant_a}, 32'd0);
    flush_a = 1'b0;
    @(negedge clk);
    chk("idle_flush_later", {30'd0, grant_a}, 32'd2);
    strobe_a = '0;
    push_exp(1, 32'h0BAD_F00D);
    mem_ready_a = 1'b1;
    mem_data_a  = 32'h0BAD_F00D;
    #1 check_sb();
    @(negedge clk);
    mem_ready_a = 1'b0;

    // Flush on ch0 (unmasked) is ignored
    @(negedge clk);
    a_a[31:0] = 32'h0000_4000;
    strobe_a = 2'b01;
    @(negedge clk);
    flush_a = 1'b1;
    strobe_a = '0;
    push_exp(0, 32'h7777_0000);
    @(negedge clk);
    flush_a = 1'b0;
    mem_ready_a = 1'b1;
    mem_data_a  = 32'h7777_0000;
    #1 check_sb();
    @(negedge clk);
    mem_ready_a = 1'b0;

    // Round robin on instance B, all strobes held
    @(negedge clk);
    a_b = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100, 32'h0000_0000};
    strobe_b = 4'hF;
    for (int i = 0; i < 5; i++) begin
      logic [3:0] eg;
      eg = 4'b0001 << (i % 4);
      @(negedge clk);
      chk("rr_grant", {28'd0, grant_b}, {28'd0, eg});
      chk("rr_mem_a", mem_a_b, 32'h100 * (i % 4));
      mem_ready_b = 1'b1;
      #1 chk("rr_ready", {28'd0, ready_b}, {28'd0, eg});
      @(negedge clk);
      mem_ready_b = 1'b0;
      chk("rr_idle", {31'd0, access_b}, 32'd0);
    end
    strobe_b = '0;

    // Asynchronous reset mid-BUSY
    @(negedge clk);
    strobe_a = 2'b10;
    @(negedge clk);
    strobe_a = '0;
    mem_ready_a = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("arst_access", {31'd0, access_a}, 32'd0);
    chk("arst_grant", {30'd0, grant_a}, 32'd0);
    chk("arst_ready", {30'd0, ready_a}, 32'd0);
    chk("arst_mem_a", mem_a_a, 32'd0);
    mem_ready_a = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("sb_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
